// File: rtl/meter_core_param.sv
// meter_core_param: keypad-driven payment meter with entry, countdown,
// top-up during countdown, idle power-down and a fixed-length alarm pulse.
module meter_core_param #(
    parameter int W            = 20,
    parameter int MAX_MONEY    = 20,
    parameter int RATE         = 2,
    parameter int TICK_DIV     = 10000,
    parameter int IDLE_TIMEOUT = 100000,
    parameter int ALARM_CYCLES = 200000
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         NoShut,
    input  logic [3:0]   ReadFromKeyBoard,
    output logic [W-1:0] TimeLeft,
    output logic [W-1:0] Money,
    output logic         Light,
    output logic         Play,
    output logic [2:0]   Mode
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_IDLE  = 3'd1,
        S_ENTRY = 3'd2,
        S_COUNT = 3'd3,
        S_TOPUP = 3'd4,
        S_ALARM = 3'd5
    } state_t;

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int AW = $clog2(ALARM_CYCLES + 1);

    localparam logic [W-1:0]  MAX_W      = W'(MAX_MONEY);
    localparam logic [W-1:0]  RATE_W     = W'(RATE);
    localparam logic [W-1:0]  TMAX_W     = W'(MAX_MONEY * RATE);
    localparam logic [W-1:0]  TEN_W      = W'(10);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

    state_t        state_q, state_d;
    logic          prev_q;
    logic [W-1:0]  money_q, money_d;
    logic [W-1:0]  add_q, add_d;
    logic [W-1:0]  time_q, time_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [AW-1:0] alarm_q, alarm_d;
    logic [W-1:0]  disp_q;
    logic          light_q, play_q;

    logic          key_ev, is_digit, wrap;
    logic [3:0]    key;
    logic [W-1:0]  ed, t_dec, add_rate, topped;
    logic [W:0]    sum_w;

    // Digit append saturates before the write; backspace drops the last digit.
    function automatic logic [W-1:0] edit(input logic [W-1:0] v, input logic [3:0] k);
        logic [W-1:0] n;
        n = v;
        if (k <= 4'd9) begin
            n = v * TEN_W + W'(k);
            if (n > MAX_W) n = MAX_W;
        end else if (k == 4'd10) begin
            n = v / TEN_W;
        end
        return n;
    endfunction

    assign key      = ReadFromKeyBoard;
    assign key_ev   = prev_q & ~NoShut;
    assign is_digit = (key <= 4'd9);
    assign wrap     = (tick_q == TICK_LAST);
    assign ed       = edit((state_q == S_TOPUP) ? add_q : money_q, key);
    // Tick decrement is applied first, then the top-up, then the clamp.
    assign t_dec    = wrap ? time_q - 1'b1 : time_q;
    assign add_rate = add_q * RATE_W;
    assign sum_w    = {1'b0, t_dec} + {1'b0, add_rate};
    assign topped   = (sum_w > {1'b0, TMAX_W}) ? TMAX_W : sum_w[W-1:0];

    // Next-state and datapath updates; power-off and counter clears override last.
    always_comb begin
        state_d = state_q;
        money_d = money_q;
        add_d   = add_q;
        time_d  = time_q;
        tick_d  = tick_q;
        idle_d  = idle_q;
        alarm_d = alarm_q;
        case (state_q)
            S_OFF: begin
                if (key_ev && key == 4'd11) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (key_ev) begin
                    idle_d = '0;
                    if (is_digit) begin
                        money_d = ed;
                        time_d  = ed * RATE_W;
                        state_d = S_ENTRY;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d = S_OFF;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_ENTRY: begin
                if (key_ev) begin
                    idle_d = '0;
                    if (is_digit || key == 4'd10) begin
                        money_d = ed;
                        time_d  = ed * RATE_W;
                    end else if (key == 4'd12) begin
                        money_d = '0;
                        time_d  = '0;
                        state_d = S_IDLE;
                    end else if (key == 4'd13 && money_q != '0) begin
                        state_d = S_COUNT;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    money_d = '0;
                    time_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_COUNT: begin
                tick_d = wrap ? '0 : tick_q + 1'b1;
                time_d = t_dec;
                if (wrap && t_dec == '0) begin
                    money_d = '0;
                    state_d = S_ALARM;
                end else if (key_ev && key == 4'd14) begin
                    add_d   = '0;
                    state_d = S_TOPUP;
                end
            end
            S_TOPUP: begin
                tick_d = wrap ? '0 : tick_q + 1'b1;
                time_d = (key_ev && key == 4'd13) ? topped : t_dec;
                if (wrap && time_d == '0) begin
                    money_d = '0;
                    add_d   = '0;
                    state_d = S_ALARM;
                end else if (key_ev) begin
                    if (is_digit || key == 4'd10) begin
                        add_d = ed;
                    end else if (key == 4'd12 || key == 4'd13) begin
                        add_d   = '0;
                        state_d = S_COUNT;
                    end
                end
            end
            S_ALARM: begin
                if (alarm_q == ALARM_LAST) state_d = S_IDLE;
                else                       alarm_d = alarm_q + 1'b1;
            end
            default: state_d = S_OFF;
        endcase

        if (state_q != S_OFF && key_ev && key == 4'd15) begin
            state_d = S_OFF;
            money_d = '0;
            add_d   = '0;
            time_d  = '0;
        end

        // Counters restart on every state change; the tick keeps running
        // between COUNT and TOPUP so the countdown is unaffected by top-up.
        if (state_d != state_q) begin
            idle_d  = '0;
            alarm_d = '0;
        end
        if (!((state_d == S_COUNT || state_d == S_TOPUP) &&
              (state_q == S_COUNT || state_q == S_TOPUP)))
            tick_d = '0;
    end

    // State, datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_OFF;
            prev_q  <= 1'b0;
            money_q <= '0;
            add_q   <= '0;
            time_q  <= '0;
            tick_q  <= '0;
            idle_q  <= '0;
            alarm_q <= '0;
            disp_q  <= '0;
            light_q <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= NoShut;
            money_q <= money_d;
            add_q   <= add_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            idle_q  <= idle_d;
            alarm_q <= alarm_d;
            disp_q  <= (state_d == S_TOPUP) ? add_d : money_d;
            light_q <= (state_d != S_OFF);
            play_q  <= (state_d == S_ALARM);
        end
    end

    assign TimeLeft = time_q;
    assign Money    = disp_q;
    assign Light    = light_q;
    assign Play     = play_q;
    assign Mode     = state_q;

endmodule

// File: tb/tb_meter_core_param.sv
// Directed bench for meter_core_param with TICK_DIV=4, IDLE_TIMEOUT=50,
// ALARM_CYCLES=8. A press drives the key low at a falling edge, so the event
// edge is the next rising edge (E0); press returns at the falling edge after E1.
module tb_meter_core_param;

    localparam int W = 20;

    logic         CLK;
    logic         Reset;
    logic         NoShut;
    logic [3:0]   Key;
    logic [W-1:0] TimeLeft;
    logic [W-1:0] Money;
    logic         Light;
    logic         Play;
    logic [2:0]   Mode;

    int n_chk = 0;
    int n_err = 0;

    meter_core_param #(
        .W(W), .MAX_MONEY(20), .RATE(2),
        .TICK_DIV(4), .IDLE_TIMEOUT(50), .ALARM_CYCLES(8)
    ) dut (
        .CLK(CLK), .Reset(Reset), .NoShut(NoShut), .ReadFromKeyBoard(Key),
        .TimeLeft(TimeLeft), .Money(Money), .Light(Light), .Play(Play), .Mode(Mode)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ends at a falling edge with one rising edge seen at NoShut=1 after release.
    task automatic rst();
        Reset  = 1'b1;
        NoShut = 1'b1;
        Key    = 4'd0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
    endtask

    // Called at a falling edge; event lands on the following rising edge.
    task automatic press(input logic [3:0] k);
        Key    = k;
        NoShut = 1'b0;
        @(negedge CLK);
        NoShut = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1; NoShut = 1'b1; Key = 4'd0;
        rst();
        chk("rst_mode",  32'(Mode), 0);
        chk("rst_time",  32'(TimeLeft), 0);
        chk("rst_money", 32'(Money), 0);
        chk("rst_light", 32'(Light), 0);
        chk("rst_play",  32'(Play), 0);

        // 1: pay 15, 30 units at 4 cycles each, then 8-cycle alarm
        press(4'd11); press(4'd1); press(4'd5);
        chk("t1_money_entry", 32'(Money), 15);
        press(4'd13);                                   // at E1
        chk("t1_mode", 32'(Mode), 3);
        chk("t1_time0", 32'(TimeLeft), 30);
        repeat (3) @(negedge CLK);                      // E4: first decrement
        chk("t1_time_first_dec", 32'(TimeLeft), 29);
        repeat (115) @(negedge CLK);                    // E119
        chk("t1_time_last", 32'(TimeLeft), 1);
        chk("t1_mode_last", 32'(Mode), 3);
        @(negedge CLK);                                 // E120
        chk("t1_alarm_mode", 32'(Mode), 5);
        chk("t1_alarm_play", 32'(Play), 1);
        chk("t1_alarm_time", 32'(TimeLeft), 0);
        chk("t1_alarm_money", 32'(Money), 0);
        repeat (7) @(negedge CLK);                      // E127
        chk("t1_play_end", 32'(Play), 1);
        @(negedge CLK);                                 // E128
        chk("t1_play_off", 32'(Play), 0);
        chk("t1_idle_mode", 32'(Mode), 1);

        // 2: ignored keys, saturation, backspace, cancel
        rst();
        press(4'd13);
        chk("t2_off_ignores", 32'(Mode), 0);
        press(4'd11); press(4'd0); press(4'd13);
        chk("t2_zero_confirm", 32'(Mode), 2);
        press(4'd12);
        press(4'd9); press(4'd9);
        chk("t2_sat_money", 32'(Money), 20);
        chk("t2_sat_time", 32'(TimeLeft), 40);
        press(4'd10);
        chk("t2_bs_money", 32'(Money), 2);
        chk("t2_bs_time", 32'(TimeLeft), 4);
        press(4'd12);
        chk("t2_cancel_mode", 32'(Mode), 1);
        chk("t2_cancel_money", 32'(Money), 0);
        chk("t2_cancel_time", 32'(TimeLeft), 0);

        // 3: top-up; ticks fall at E4,E8,E12,... relative to the confirm edge
        rst();
        press(4'd11); press(4'd5);
        chk("t3_time_paid", 32'(TimeLeft), 10);
        press(4'd13);                                   // at E1
        repeat (7) @(negedge CLK);                      // E8
        chk("t3_time8", 32'(TimeLeft), 8);
        press(4'd14);                                   // event E9
        press(4'd7);                                    // event E11, tick E12 -> 7
        chk("t3_add_money", 32'(Money), 7);
        chk("t3_topup_mode", 32'(Mode), 4);
        chk("t3_time7", 32'(TimeLeft), 7);
        press(4'd13);                                   // event E13: 7 + 7*2
        chk("t3_topped", 32'(TimeLeft), 21);
        chk("t3_money_restore", 32'(Money), 5);
        chk("t3_count_mode", 32'(Mode), 3);
        press(4'd14); press(4'd9); press(4'd9);         // E15,E17,E19; tick E16,E20
        chk("t3_add_sat", 32'(Money), 20);
        press(4'd13);                                   // E21: 19 + 40 -> clamp 40
        chk("t3_clamp", 32'(TimeLeft), 40);

        // 4: top-up expiry discards Add
        rst();
        press(4'd11); press(4'd1);
        press(4'd13);                                   // E0, time 2
        press(4'd14);                                   // E2
        press(4'd3);                                    // E4: Add=3, time 1
        chk("t4_time1", 32'(TimeLeft), 1);
        chk("t4_add", 32'(Money), 3);
        repeat (3) @(negedge CLK);                      // E8
        chk("t4_mode", 32'(Mode), 5);
        chk("t4_time", 32'(TimeLeft), 0);
        chk("t4_money", 32'(Money), 0);

        // 5: idle timeouts (50 cycles after last state entry)
        rst();
        press(4'd11);                                   // E0, now at E1
        repeat (48) @(negedge CLK);                     // E49
        chk("t5_before_to", 32'(Mode), 1);
        @(negedge CLK);                                 // E50
        chk("t5_off_mode", 32'(Mode), 0);
        chk("t5_off_light", 32'(Light), 0);
        press(4'd11);
        press(4'd1);                                    // entry at E2, now E3
        repeat (48) @(negedge CLK);                     // E51
        chk("t5_entry_hold", 32'(Money), 1);
        @(negedge CLK);                                 // E52
        chk("t5_entry_to_mode", 32'(Mode), 1);
        chk("t5_entry_to_money", 32'(Money), 0);
        chk("t5_entry_to_time", 32'(TimeLeft), 0);

        // 6: power-off during count, reset mid-top-up with key held
        rst();
        press(4'd11); press(4'd3); press(4'd13);
        Key = 4'd15; NoShut = 1'b0;
        @(negedge CLK);
        chk("t6_off_mode", 32'(Mode), 0);
        chk("t6_off_time", 32'(TimeLeft), 0);
        chk("t6_off_money", 32'(Money), 0);
        chk("t6_off_light", 32'(Light), 0);
        NoShut = 1'b1;
        @(negedge CLK);
        press(4'd11); press(4'd3); press(4'd13); press(4'd14);
        chk("t6_in_topup", 32'(Mode), 4);
        Key = 4'd11; NoShut = 1'b0; Reset = 1'b1;
        @(negedge CLK);
        chk("t6_rst_mode", 32'(Mode), 0);
        chk("t6_rst_time", 32'(TimeLeft), 0);
        Reset = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t6_no_event", 32'(Mode), 0);
        NoShut = 1'b1;
        @(negedge CLK);
        press(4'd11);
        chk("t6_alive", 32'(Mode), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
